rst_sequencer: RTL

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: waits for PLL lock, settles, then releases
// peripheral reset followed by core reset, counting post-settle lock losses.
module rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       periph_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] drop_cnt
);

    localparam int MAXC = (SETTLE_CYCLES > STAGGER_CYCLES) ?
                          SETTLE_CYCLES : STAGGER_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        SETTLE    = 2'b01,
        RELEASE   = 2'b10,
        RUN       = 2'b11
    } state_t;

    state_t                 cur;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic [CW-1:0]          cnt;

    // {periph_rst, core_rst, ready} for a given state
    function automatic logic [2:0] outs(input state_t s);
        unique case (s)
            WAIT_LOCK: outs = 3'b110;
            SETTLE:    outs = 3'b110;
            RELEASE:   outs = 3'b010;
            RUN:       outs = 3'b001;
        endcase
    endfunction

    assign locked_s = sync[SYNC_STAGES-1];
    assign state    = cur;

    // Bring the asynchronous lock indicator into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
        end
    end

    // Sequencer FSM; outputs are loaded with the decode of the next state
    // so they always match the state register without an extra cycle lag
    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= WAIT_LOCK;
            cnt        <= '0;
            drop_cnt   <= '0;
            periph_rst <= 1'b1;
            core_rst   <= 1'b1;
            ready      <= 1'b0;
        end else begin
            unique case (cur)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (locked_s) begin
                        cur <= SETTLE;
                        {periph_rst, core_rst, ready} <= outs(SETTLE);
                    end
                end
                SETTLE: begin
                    if (!locked_s) begin
                        cur <= WAIT_LOCK;
                        cnt <= '0;
                        {periph_rst, core_rst, ready} <= outs(WAIT_LOCK);
                    end else if (cnt == SETTLE_LAST) begin
                        cur <= RELEASE;
                        cnt <= '0;
                        {periph_rst, core_rst, ready} <= outs(RELEASE);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!locked_s) begin
                        cur <= WAIT_LOCK;
                        cnt <= '0;
                        {periph_rst, core_rst, ready} <= outs(WAIT_LOCK);
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end else if (cnt == STAGGER_LAST) begin
                        cur <= RUN;
                        cnt <= '0;
                        {periph_rst, core_rst, ready} <= outs(RUN);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    cnt <= '0;
                    if (!locked_s) begin
                        cur <= WAIT_LOCK;
                        {periph_rst, core_rst, ready} <= outs(WAIT_LOCK);
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
